flr_issue: RTL and testbench
============================

Name: flr_issue

Overview:
Issue/operand-fetch front end of the Tomasulo core; it is the register-file (FLR) side of the FLR<->reservation-station interface.
- Holds the architectural register file plus a per-register producer-tag (register status) table.
- Accepts one decoded instruction at a time and reads each operand as either a value or a producer tag.
- Dispatches the instruction to the ALU or MUL reservation station and records the returned RS tag as the new producer of rd.
- Snoops the common data bus (CDB) to retire tags into register values.

Parameters:
XLEN, 32, data width
NREG, 32, architectural registers (index width 5)
TAGW, 5, tag width
TAG_VALID, 5'h1F, tag value meaning "value present, no producer"

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
iq_valid  in  1  decoded instruction available
iq_ready  out  1  block can accept an instruction (IDLE only)
iq_opcode  in  6  opcode, passed through to the RS
iq_rs1  in  5  source register 1
iq_rs2  in  5  source register 2
iq_rd  in  5  destination register
iq_unit  in  1  0 = ALU RS, 1 = MUL RS
alu_req_valid  out  1  dispatch request to ALU RS
mul_req_valid  out  1  dispatch request to MUL RS
rs_opcode  out  6  dispatched opcode
rs_tag1  out  5  operand 1 producer tag, or TAG_VALID
rs_tag2  out  5  operand 2 producer tag, or TAG_VALID
rs_data1  out  32  operand 1 value; meaningful only when rs_tag1==TAG_VALID
rs_data2  out  32  operand 2 value; meaningful only when rs_tag2==TAG_VALID
rs_dest  out  5  rd, passed through
rs_grant  in  1  selected RS accepted the request this cycle
rs_grant_tag  in  5  RS entry tag allocated (ALU 0-7, MUL 16-23)
cdb_valid  in  1  result broadcast valid
cdb_tag  in  5  producer tag of the broadcast
cdb_data  in  32  broadcast value
dbg_addr  in  5  debug read index
dbg_data  out  32  regs[dbg_addr], combinational
dbg_tag  out  5  stat[dbg_addr], combinational

Behaviour:
- Reset (rst==0 at posedge):
  - All regs = 0 and all stat = TAG_VALID.
  - FSM = IDLE; alu_req_valid = mul_req_valid = 0.
  - rs_tag1/2 = TAG_VALID; rs_data1/2, rs_opcode, rs_dest = 0.
  - Reset mid-dispatch drops the pending request; no register status is written.
- FSM states: IDLE, DISPATCH.
  - IDLE: iq_ready = 1. On iq_valid, capture the instruction and operands, then go to DISPATCH.
  - DISPATCH: iq_ready = 0. Exactly one of alu_req_valid/mul_req_valid is high (per iq_unit) and the payload is stable.
  - On rs_grant: set stat[rd] = rs_grant_tag, deassert the request, return to IDLE.
- Latency: instruction accepted at cycle N, request visible at N+1, earliest grant at N+1, next accept at N+2. Throughput is therefore one instruction per 2 cycles.
- Operand capture, per source s at acceptance:
  - s==0: tag = TAG_VALID, data = 0.
  - else if stat[s]==TAG_VALID: data = regs[s].
  - else if cdb_valid and cdb_tag==stat[s]: bypass, tag = TAG_VALID, data = cdb_data.
  - else: tag = stat[s], data = 0.
- CDB snoop, every cycle with cdb_valid and cdb_tag!=TAG_VALID:
  - Every r with stat[r]==cdb_tag: regs[r] = cdb_data, stat[r] = TAG_VALID.
  - A latched operand in DISPATCH whose tag matches cdb_tag converts to value form in the next cycle.
- Simultaneous grant and CDB on the same rd: the grant wins. stat[rd] = rs_grant_tag and regs[rd] takes cdb_data only if the old tag matched.
- rd==0: dispatch still occurs; stat[0] is never written and stays TAG_VALID; regs[0] stays 0.
- rs_grant while not in DISPATCH is ignored.
- rs_grant_tag==TAG_VALID is a protocol error: stat is left unchanged; it is covered by an assertion in simulation only.

Optional Feature:
FLR_STALL_CNT_EN:
- When defined, adds outputs stall_cycles[31:0] and issued_cnt[31:0].
  - stall_cycles: cycles in DISPATCH without grant.
  - issued_cnt: grants.
  - Both clear on reset and saturate at all-ones.
- When undefined, these ports and counters do not exist.

Decomposition:
- Package tomasulo_pkg holds: TAG_VALID, TAGW/XLEN, the unit_e enum (UNIT_ALU, UNIT_MUL), the RS tag base constants (ALU_TAG_BASE = 0, MUL_TAG_BASE = 16, RS_DEPTH = 8), and the opcode width.
- Sub-module flr_regstat holds the regs + stat arrays, the CDB snoop, two read ports with CDB bypass, one status-write port and the debug port.
- flr_issue keeps the FSM and the request payload.

Test Plan:
- Reset then dbg sweep -> every dbg_tag = 5'h1F, every dbg_data = 0, iq_ready = 1.
- Issue MUL rd=3, rs1=1, rs2=2, grant tag 16 -> mul_req_valid high for 1 cycle, rs_tag1 = rs_tag2 = 5'h1F; afterwards stat[3] = 16.
- Issue ALU rs1=3 while stat[3]=16, then CDB tag 16 data 0x2A one cycle into DISPATCH -> rs_tag1 = 16, next cycle rs_tag1 = 5'h1F and rs_data1 = 0x2A; regs[3] = 0x2A, stat[3] = 5'h1F.
- Accept with cdb_tag==stat[rs2]=17 in the same cycle -> request shows rs_tag2 = 5'h1F, rs_data2 = cdb_data.
- Grant tag 18 for rd=5 in the same cycle as CDB tag 16 where stat[5]=16 -> stat[5] = 18, regs[5] = CDB value.
- rst low while in DISPATCH -> next cycle alu_req_valid = mul_req_valid = 0, stat all TAG_VALID, iq_ready = 1 after release.

Source files
------------

// File: rtl/tomasulo_pkg.sv
// Shared constants and types for the Tomasulo issue front end.
// Contents: data/tag/register-index widths, the TAG_VALID sentinel,
// RS tag bases, the dispatch unit selector, the issue FSM state type and
// the operand-fetch helper used by the register/status block.
package tomasulo_pkg;
  localparam int XLEN     = 32;
  localparam int TAGW     = 5;
  localparam int NREG     = 32;
  localparam int REGW     = 5;
  localparam int OPW      = 6;
  localparam int RS_DEPTH = 8;

  // Tag value meaning "register holds its value, nobody is producing it".
  localparam logic [TAGW-1:0] TAG_VALID    = 5'h1F;
  localparam logic [TAGW-1:0] ALU_TAG_BASE = 5'd0;
  localparam logic [TAGW-1:0] MUL_TAG_BASE = 5'd16;

  typedef enum logic {
    UNIT_ALU = 1'b0,
    UNIT_MUL = 1'b1
  } unit_e;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_DISPATCH = 1'b1
  } issue_state_e;

  // Resolve one source operand to {tag, data}. x0 is always the constant 0;
  // a pending producer that is broadcasting right now is bypassed from the CDB.
  function automatic logic [TAGW+XLEN-1:0] operand_fetch(
    input logic [REGW-1:0] addr,
    input logic [TAGW-1:0] stat,
    input logic [XLEN-1:0] value,
    input logic            cdb_valid,
    input logic [TAGW-1:0] cdb_tag,
    input logic [XLEN-1:0] cdb_data
  );
    if (addr == '0)
      return {TAG_VALID, {XLEN{1'b0}}};
    else if (stat == TAG_VALID)
      return {TAG_VALID, value};
    else if (cdb_valid && (cdb_tag == stat))
      return {TAG_VALID, cdb_data};
    else
      return {stat, {XLEN{1'b0}}};
  endfunction
endpackage

// File: rtl/flr_issue_if.sv
// Issue-queue, reservation-station and CDB signals seen by the FLR.
// master: the FLR issue block (accepts instructions, drives RS requests).
// slave : the environment (issue queue, reservation stations, CDB).
interface flr_issue_if;
  import tomasulo_pkg::*;

  logic            iq_valid;
  logic            iq_ready;
  logic [OPW-1:0]  iq_opcode;
  logic [REGW-1:0] iq_rs1;
  logic [REGW-1:0] iq_rs2;
  logic [REGW-1:0] iq_rd;
  logic            iq_unit;

  logic            alu_req_valid;
  logic            mul_req_valid;
  logic [OPW-1:0]  rs_opcode;
  logic [TAGW-1:0] rs_tag1;
  logic [TAGW-1:0] rs_tag2;
  logic [XLEN-1:0] rs_data1;
  logic [XLEN-1:0] rs_data2;
  logic [REGW-1:0] rs_dest;
  logic            rs_grant;
  logic [TAGW-1:0] rs_grant_tag;

  logic            cdb_valid;
  logic [TAGW-1:0] cdb_tag;
  logic [XLEN-1:0] cdb_data;

  modport master (
    input  iq_valid, iq_opcode, iq_rs1, iq_rs2, iq_rd, iq_unit,
    output iq_ready,
    output alu_req_valid, mul_req_valid, rs_opcode, rs_tag1, rs_tag2,
    output rs_data1, rs_data2, rs_dest,
    input  rs_grant, rs_grant_tag,
    input  cdb_valid, cdb_tag, cdb_data
  );

  modport slave (
    output iq_valid, iq_opcode, iq_rs1, iq_rs2, iq_rd, iq_unit,
    input  iq_ready,
    input  alu_req_valid, mul_req_valid, rs_opcode, rs_tag1, rs_tag2,
    input  rs_data1, rs_data2, rs_dest,
    output rs_grant, rs_grant_tag,
    output cdb_valid, cdb_tag, cdb_data
  );
endinterface

// File: rtl/flr_regstat.sv
// Architectural register file plus per-register producer-tag table.
// Ports: clk, rst (sync, active-low); two operand read ports (rd_addr1/2 ->
// rd_tag1/2, rd_data1/2) with CDB bypass; one status write port
// (wr_en/wr_addr/wr_tag); CDB snoop (cdb_valid/cdb_tag/cdb_data);
// combinational debug read (dbg_addr -> dbg_data/dbg_tag).
module flr_regstat
  import tomasulo_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [REGW-1:0] rd_addr1,
  input  logic [REGW-1:0] rd_addr2,
  output logic [TAGW-1:0] rd_tag1,
  output logic [TAGW-1:0] rd_tag2,
  output logic [XLEN-1:0] rd_data1,
  output logic [XLEN-1:0] rd_data2,
  input  logic            wr_en,
  input  logic [REGW-1:0] wr_addr,
  input  logic [TAGW-1:0] wr_tag,
  input  logic            cdb_valid,
  input  logic [TAGW-1:0] cdb_tag,
  input  logic [XLEN-1:0] cdb_data,
  input  logic [REGW-1:0] dbg_addr,
  output logic [XLEN-1:0] dbg_data,
  output logic [TAGW-1:0] dbg_tag
);
  logic [XLEN-1:0] regs_reg [NREG];
  logic [TAGW-1:0] stat_reg [NREG];
  logic [NREG-1:0] snoop_hit;

  // Per-register retire match; TAG_VALID broadcasts never retire anything.
  for (genvar gi = 0; gi < NREG; gi++) begin : g_hit
    assign snoop_hit[gi] = cdb_valid && (cdb_tag != TAG_VALID) && (stat_reg[gi] == cdb_tag);
  end

  // Register 0 is only touched by reset, so it stays 0 / TAG_VALID.
  // The status write comes after the snoop so a same-cycle grant wins on stat,
  // while the value still retires from the CDB if the old tag matched.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int r = 0; r < NREG; r++) begin
        regs_reg[r] <= '0;
        stat_reg[r] <= TAG_VALID;
      end
    end else begin
      for (int r = 1; r < NREG; r++) begin
        if (snoop_hit[r]) begin
          regs_reg[r] <= cdb_data;
          stat_reg[r] <= TAG_VALID;
        end
        if (wr_en && (wr_addr == REGW'(r)) && (wr_tag != TAG_VALID))
          stat_reg[r] <= wr_tag;
      end
    end
  end

  assign {rd_tag1, rd_data1} = operand_fetch(rd_addr1, stat_reg[rd_addr1], regs_reg[rd_addr1],
                                             cdb_valid, cdb_tag, cdb_data);
  assign {rd_tag2, rd_data2} = operand_fetch(rd_addr2, stat_reg[rd_addr2], regs_reg[rd_addr2],
                                             cdb_valid, cdb_tag, cdb_data);

  assign dbg_data = regs_reg[dbg_addr];
  assign dbg_tag  = stat_reg[dbg_addr];
endmodule

// File: rtl/flr_issue.sv
// FLR issue / operand-fetch front end: accepts one decoded instruction,
// resolves its operands to values or producer tags, holds a dispatch request
// to the ALU or MUL reservation station until granted and records the
// granted RS tag as the new producer of rd.
// Ports: clk, rst (sync, active-low); bus (flr_issue_if.master: issue queue,
// RS request/grant, CDB); dbg_addr -> dbg_data/dbg_tag (combinational).
// Optional: define FLR_STALL_CNT_EN to add saturating counters
// stall_cycles (dispatch cycles without grant) and issued_cnt (grants).
module flr_issue
  import tomasulo_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  flr_issue_if.master     bus,
  input  logic [REGW-1:0] dbg_addr,
  output logic [XLEN-1:0] dbg_data,
  output logic [TAGW-1:0] dbg_tag
`ifdef FLR_STALL_CNT_EN
  ,
  output logic [31:0]     stall_cycles,
  output logic [31:0]     issued_cnt
`endif
);
  issue_state_e    state_reg, state_next;
  logic            accept, grant, cdb_live;
  logic [OPW-1:0]  opcode_reg;
  logic [REGW-1:0] dest_reg;
  unit_e           unit_reg;
  logic [TAGW-1:0] fetch_tag  [2];
  logic [XLEN-1:0] fetch_data [2];

  assign cdb_live = bus.cdb_valid && (bus.cdb_tag != TAG_VALID);

  always_ff @(posedge clk) begin
    if (!rst) state_reg <= ST_IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next        = state_reg;
    bus.iq_ready      = 1'b0;
    bus.alu_req_valid = 1'b0;
    bus.mul_req_valid = 1'b0;
    accept            = 1'b0;
    grant             = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        bus.iq_ready = 1'b1;
        if (bus.iq_valid) begin
          accept     = 1'b1;
          state_next = ST_DISPATCH;
        end
      end
      ST_DISPATCH: begin
        bus.alu_req_valid = (unit_reg == UNIT_ALU);
        bus.mul_req_valid = (unit_reg == UNIT_MUL);
        if (bus.rs_grant) begin
          grant      = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      opcode_reg <= '0;
      dest_reg   <= '0;
      unit_reg   <= UNIT_ALU;
    end else if (accept) begin
      opcode_reg <= bus.iq_opcode;
      dest_reg   <= bus.iq_rd;
      unit_reg   <= unit_e'(bus.iq_unit);
    end
  end

  // Latched operands: captured on accept, then woken up by a matching CDB
  // broadcast while the request waits for its grant.
  for (genvar gi = 0; gi < 2; gi++) begin : g_opnd
    logic [TAGW-1:0] tag_reg;
    logic [XLEN-1:0] data_reg;
    always_ff @(posedge clk) begin
      if (!rst) begin
        tag_reg  <= TAG_VALID;
        data_reg <= '0;
      end else if (accept) begin
        tag_reg  <= fetch_tag[gi];
        data_reg <= fetch_data[gi];
      end else if ((state_reg == ST_DISPATCH) && cdb_live && (tag_reg == bus.cdb_tag)) begin
        tag_reg  <= TAG_VALID;
        data_reg <= bus.cdb_data;
      end
    end
  end

  assign bus.rs_opcode = opcode_reg;
  assign bus.rs_dest   = dest_reg;
  assign bus.rs_tag1   = g_opnd[0].tag_reg;
  assign bus.rs_tag2   = g_opnd[1].tag_reg;
  assign bus.rs_data1  = g_opnd[0].data_reg;
  assign bus.rs_data2  = g_opnd[1].data_reg;

  flr_regstat u_regstat (
    .clk       (clk),
    .rst       (rst),
    .rd_addr1  (bus.iq_rs1),
    .rd_addr2  (bus.iq_rs2),
    .rd_tag1   (fetch_tag[0]),
    .rd_tag2   (fetch_tag[1]),
    .rd_data1  (fetch_data[0]),
    .rd_data2  (fetch_data[1]),
    .wr_en     (grant),
    .wr_addr   (dest_reg),
    .wr_tag    (bus.rs_grant_tag),
    .cdb_valid (bus.cdb_valid),
    .cdb_tag   (bus.cdb_tag),
    .cdb_data  (bus.cdb_data),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data),
    .dbg_tag   (dbg_tag)
  );

`ifdef FLR_STALL_CNT_EN
  logic [31:0] stall_reg, issued_reg;
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_reg  <= '0;
      issued_reg <= '0;
    end else begin
      if ((state_reg == ST_DISPATCH) && !bus.rs_grant && (stall_reg != '1))
        stall_reg <= stall_reg + 32'd1;
      if (grant && (issued_reg != '1))
        issued_reg <= issued_reg + 32'd1;
    end
  end
  assign stall_cycles = stall_reg;
  assign issued_cnt   = issued_reg;
`endif

`ifndef SYNTHESIS
  // A grant carrying TAG_VALID would make rd look ready; stat ignores it.
  always_ff @(posedge clk) begin
    if (rst && grant) begin
      assert (bus.rs_grant_tag != TAG_VALID)
        else $error("flr_issue: rs_grant_tag equals TAG_VALID");
    end
  end
`endif
endmodule

// File: tb/tb_flr_issue.sv
module tb_flr_issue;
  import tomasulo_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  flr_issue_if bus();
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic [4:0]  dbg_tag;
`ifdef FLR_STALL_CNT_EN
  logic [31:0] stall_cycles, issued_cnt;
`endif

  flr_issue dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .dbg_tag  (dbg_tag)
`ifdef FLR_STALL_CNT_EN
    ,
    .stall_cycles (stall_cycles),
    .issued_cnt   (issued_cnt)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: architectural state and the one outstanding request.
  logic [31:0] m_regs [32];
  logic [4:0]  m_stat [32];
  bit          m_busy;
  bit          m_unit;
  logic [5:0]  m_op;
  logic [4:0]  m_dest, m_t1, m_t2;
  logic [31:0] m_d1, m_d2;
  longint      m_stall, m_issued;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
      else begin
        n_bad++;
        $error("FAIL %s observed=%h expected=%h", name, obs, exp);
      end
  endtask

  // Operand as the issue rules define it, from the model's current state.
  function automatic logic [36:0] m_fetch(input logic [4:0] s);
    if (s == 5'd0) return {5'h1F, 32'h0};
    if (m_stat[s] == 5'h1F) return {5'h1F, m_regs[s]};
    if (bus.cdb_valid && bus.cdb_tag == m_stat[s]) return {5'h1F, bus.cdb_data};
    return {m_stat[s], 32'h0};
  endfunction

  task automatic idle();
    bus.iq_valid = 0; bus.iq_opcode = 0; bus.iq_rs1 = 0; bus.iq_rs2 = 0;
    bus.iq_rd = 0; bus.iq_unit = 0;
    bus.rs_grant = 0; bus.rs_grant_tag = 0;
    bus.cdb_valid = 0; bus.cdb_tag = 0; bus.cdb_data = 0;
  endtask

  task automatic issue(input bit unit, input logic [5:0] op, input logic [4:0] s1,
                       input logic [4:0] s2, input logic [4:0] rd);
    bus.iq_valid = 1; bus.iq_unit = unit; bus.iq_opcode = op;
    bus.iq_rs1 = s1; bus.iq_rs2 = s2; bus.iq_rd = rd;
  endtask

  // One clock: advance the model on the inputs now applied, then compare.
  task automatic cyc();
    logic [36:0] f1, f2;
    bit acc, gnt;
    if (!rst) begin
      for (int r = 0; r < 32; r++) begin m_regs[r] = 0; m_stat[r] = 5'h1F; end
      m_busy = 0; m_unit = 0; m_op = 0; m_dest = 0;
      m_t1 = 5'h1F; m_t2 = 5'h1F; m_d1 = 0; m_d2 = 0;
      m_stall = 0; m_issued = 0;
    end else begin
      f1  = m_fetch(bus.iq_rs1);
      f2  = m_fetch(bus.iq_rs2);
      acc = !m_busy && bus.iq_valid;
      gnt = m_busy && bus.rs_grant;
      if (gnt) m_issued++;
      else if (m_busy) m_stall++;
      if (bus.cdb_valid && bus.cdb_tag != 5'h1F) begin
        for (int r = 0; r < 32; r++)
          if (m_stat[r] == bus.cdb_tag) begin m_regs[r] = bus.cdb_data; m_stat[r] = 5'h1F; end
        if (m_busy && m_t1 == bus.cdb_tag) begin m_t1 = 5'h1F; m_d1 = bus.cdb_data; end
        if (m_busy && m_t2 == bus.cdb_tag) begin m_t2 = 5'h1F; m_d2 = bus.cdb_data; end
      end
      if (gnt) begin
        if (m_dest != 0 && bus.rs_grant_tag != 5'h1F) m_stat[m_dest] = bus.rs_grant_tag;
        m_busy = 0;
      end
      if (acc) begin
        m_busy = 1; m_unit = bus.iq_unit; m_op = bus.iq_opcode; m_dest = bus.iq_rd;
        {m_t1, m_d1} = f1;
        {m_t2, m_d2} = f2;
      end
    end
    @(posedge clk);
    #1;
    chk("iq_ready", 32'(bus.iq_ready), 32'(!m_busy));
    chk("alu_req_valid", 32'(bus.alu_req_valid), 32'(m_busy && !m_unit));
    chk("mul_req_valid", 32'(bus.mul_req_valid), 32'(m_busy && m_unit));
    if (m_busy) begin
      chk("rs_opcode", 32'(bus.rs_opcode), 32'(m_op));
      chk("rs_dest", 32'(bus.rs_dest), 32'(m_dest));
      chk("rs_tag1", 32'(bus.rs_tag1), 32'(m_t1));
      chk("rs_tag2", 32'(bus.rs_tag2), 32'(m_t2));
      chk("rs_data1", bus.rs_data1, m_d1);
      chk("rs_data2", bus.rs_data2, m_d2);
    end
    chk("dbg_tag", 32'(dbg_tag), 32'(m_stat[dbg_addr]));
    chk("dbg_data", dbg_data, m_regs[dbg_addr]);
`ifdef FLR_STALL_CNT_EN
    chk("stall_cycles", stall_cycles, (m_stall > 64'hFFFFFFFF) ? 32'hFFFFFFFF : 32'(m_stall));
    chk("issued_cnt", issued_cnt, (m_issued > 64'hFFFFFFFF) ? 32'hFFFFFFFF : 32'(m_issued));
`endif
  endtask

  task automatic sweep();
    idle();
    for (int a = 0; a < 32; a++) begin
      dbg_addr = 5'(a);
      cyc();
      chk("sweep_tag", 32'(dbg_tag), 32'h1F);
      chk("sweep_data", dbg_data, 32'h0);
    end
  endtask

  initial begin
    idle();
    dbg_addr = 0;
    rst = 0;
    cyc();
    cyc();
    chk("reset_rs_tag1", 32'(bus.rs_tag1), 32'h1F);
    chk("reset_rs_tag2", 32'(bus.rs_tag2), 32'h1F);
    chk("reset_rs_data1", bus.rs_data1, 32'h0);
    chk("reset_rs_opcode", 32'(bus.rs_opcode), 32'h0);
    chk("reset_rs_dest", 32'(bus.rs_dest), 32'h0);
    rst = 1;
    sweep();
    chk("reset_iq_ready", 32'(bus.iq_ready), 32'h1);

    // MUL rd=3 <- r1, r2; granted tag 16 after one request cycle.
    issue(1, 6'h21, 5'd1, 5'd2, 5'd3); dbg_addr = 3;
    cyc();
    chk("mul_req_high", 32'(bus.mul_req_valid), 32'h1);
    chk("mul_tag1", 32'(bus.rs_tag1), 32'h1F);
    chk("mul_tag2", 32'(bus.rs_tag2), 32'h1F);
    idle(); bus.rs_grant = 1; bus.rs_grant_tag = 5'd16;
    cyc();
    chk("mul_req_low", 32'(bus.mul_req_valid), 32'h0);
    chk("stat3_is_16", 32'(dbg_tag), 32'd16);

    // ALU reads r3 while tag 16 pending, CDB wakes it one cycle into DISPATCH.
    idle(); issue(0, 6'h02, 5'd3, 5'd0, 5'd4);
    cyc();
    chk("wait_tag1_16", 32'(bus.rs_tag1), 32'd16);
    idle(); bus.cdb_valid = 1; bus.cdb_tag = 5'd16; bus.cdb_data = 32'h2A;
    cyc();
    chk("woken_tag1", 32'(bus.rs_tag1), 32'h1F);
    chk("woken_data1", bus.rs_data1, 32'h2A);
    chk("regs3_2a", dbg_data, 32'h2A);
    chk("stat3_valid", 32'(dbg_tag), 32'h1F);
    idle(); bus.rs_grant = 1; bus.rs_grant_tag = 5'd0;
    cyc();

    // stat[6]=17, then accept reading r6 in the very cycle tag 17 broadcasts.
    idle(); issue(1, 6'h05, 5'd0, 5'd0, 5'd6); cyc();
    idle(); bus.rs_grant = 1; bus.rs_grant_tag = 5'd17; cyc();
    idle(); issue(0, 6'h07, 5'd1, 5'd6, 5'd7);
    bus.cdb_valid = 1; bus.cdb_tag = 5'd17; bus.cdb_data = 32'h55; dbg_addr = 6;
    cyc();
    chk("bypass_tag2", 32'(bus.rs_tag2), 32'h1F);
    chk("bypass_data2", bus.rs_data2, 32'h55);
    idle(); bus.rs_grant = 1; bus.rs_grant_tag = 5'd1; cyc();

    // stat[5]=16; grant tag 18 to rd=5 in the same cycle CDB retires tag 16.
    idle(); issue(1, 6'h09, 5'd0, 5'd0, 5'd5); cyc();
    idle(); bus.rs_grant = 1; bus.rs_grant_tag = 5'd16; cyc();
    idle(); issue(0, 6'h0A, 5'd0, 5'd0, 5'd5); cyc();
    idle(); bus.rs_grant = 1; bus.rs_grant_tag = 5'd18;
    bus.cdb_valid = 1; bus.cdb_tag = 5'd16; bus.cdb_data = 32'h77; dbg_addr = 5;
    cyc();
    chk("grant_wins_stat5", 32'(dbg_tag), 32'd18);
    chk("cdb_regs5", dbg_data, 32'h77);

    // rd=0 still dispatches but x0 stays clean.
    idle(); issue(0, 6'h0B, 5'd0, 5'd0, 5'd0); dbg_addr = 0; cyc();
    chk("rd0_alu_req", 32'(bus.alu_req_valid), 32'h1);
    idle(); bus.rs_grant = 1; bus.rs_grant_tag = 5'd2; cyc();
    chk("rd0_stat", 32'(dbg_tag), 32'h1F);

    // Grant while IDLE is ignored (stat[7] keeps tag 1).
    idle(); bus.rs_grant = 1; bus.rs_grant_tag = 5'd3; dbg_addr = 7; cyc();
    chk("idle_grant_ignored", 32'(dbg_tag), 32'd1);

    // Reset in the middle of a dispatch.
    idle(); issue(1, 6'h0C, 5'd3, 5'd7, 5'd9); cyc();
    idle(); rst = 0; cyc();
    chk("rst_alu_req", 32'(bus.alu_req_valid), 32'h0);
    chk("rst_mul_req", 32'(bus.mul_req_valid), 32'h0);
    rst = 1;
    sweep();
    chk("rst_iq_ready", 32'(bus.iq_ready), 32'h1);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      idle();
      bus.iq_valid  = ($urandom_range(0, 2) != 0);
      bus.iq_unit   = 1'($urandom_range(0, 1));
      bus.iq_opcode = 6'($urandom);
      bus.iq_rs1    = 5'($urandom);
      bus.iq_rs2    = 5'($urandom);
      bus.iq_rd     = 5'($urandom);
      bus.rs_grant  = ($urandom_range(0, 2) == 0);
      bus.rs_grant_tag = 5'($urandom_range(0, 7)) + (($urandom_range(0, 1) != 0) ? 5'd16 : 5'd0);
      bus.cdb_valid = ($urandom_range(0, 1) != 0);
      if ($urandom_range(0, 9) < 7) bus.cdb_tag = m_stat[5'($urandom)];
      else                          bus.cdb_tag = 5'($urandom);
      bus.cdb_data  = $urandom;
      dbg_addr      = 5'($urandom);
      rst           = ($urandom_range(0, 79) != 0);
      cyc();
    end
    rst = 1;
    idle();
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
